// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART framing constants, FSM states and host command codes
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam logic START_BIT     = 1'b0;
    localparam logic STOP_BIT      = 1'b1;
    localparam int   BITS_PER_BYTE = 8;

    // Response command codes understood by the host
    localparam logic [7:0] CMD_07 = 8'h07;
    localparam logic [7:0] CMD_08 = 8'h08;
    localparam logic [7:0] CMD_09 = 8'h09;
    localparam logic [7:0] CMD_1F = 8'h1F;
    localparam logic [7:0] CMD_45 = 8'h45;
    localparam logic [7:0] CMD_AA = 8'hAA;
    localparam logic [7:0] CMD_FF = 8'hFF;

endpackage

// File: rtl/response_uart_tx_if.sv
// rtl/response_uart_tx_if.sv - packet handshake and UART status bundle
interface response_uart_tx_if;
    logic       dadosPodemSerEnviados;
    logic [7:0] response_command;
    logic [7:0] response_value;
    logic       tx;
    logic       busy;
    logic       packet_done;
    logic       overflow;

    modport master (
        output dadosPodemSerEnviados, response_command, response_value,
        input  tx, busy, packet_done, overflow
    );

    modport slave (
        input  dadosPodemSerEnviados, response_command, response_value,
        output tx, busy, packet_done, overflow
    );
endinterface

// File: rtl/response_uart_tx_serializer.sv
// rtl/response_uart_tx_serializer.sv - one-byte 8N1 shifter with its own baud counter
module uart_byte_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       idle_o,
    output logic       pre_last_o,
    output logic       last_o
);

    localparam int             CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CNT_PRE  = CW'(CLKS_PER_BIT - 2);
    localparam logic [2:0]     BIT_LAST = 3'(BITS_PER_BYTE - 1);

    uart_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          bit_end;

    // State, counters, shifter and the registered line value
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= STOP_BIT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state logic; tx is derived from the next state so the line is a flop output
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        bit_end = (cnt_q == CNT_MAX);

        unique case (state_q)
            ST_IDLE: begin
                if (load_i) begin
                    state_d = ST_START;
                    shift_d = data_i;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            ST_START: begin
                cnt_d = cnt_q + CW'(1);
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                cnt_d = cnt_q + CW'(1);
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                cnt_d = cnt_q + CW'(1);
                if (bit_end) begin
                    cnt_d = '0;
                    if (load_i) begin
                        // Chain straight into the next start bit, no idle gap
                        state_d = ST_START;
                        shift_d = data_i;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        unique case (state_d)
            ST_START: tx_d = START_BIT;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = STOP_BIT;
        endcase
    end

    assign tx_o       = tx_q;
    assign idle_o     = (state_q == ST_IDLE);
    assign pre_last_o = (state_q == ST_STOP) && (cnt_q == CNT_PRE);
    assign last_o     = (state_q == ST_STOP) && bit_end;

endmodule

// File: rtl/response_uart_tx.sv
// rtl/response_uart_tx.sv - two-byte response packet UART transmitter with holding register
module response_uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic                clock,
    input  logic                reset,
    response_uart_tx_if.slave   bus
);

    logic       byte_sel_q, byte_sel_d;
    logic [7:0] pkt_val_q, pkt_val_d;
    logic       hold_full_q, hold_full_d;
    logic [7:0] hold_cmd_q, hold_cmd_d;
    logic [7:0] hold_val_q, hold_val_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       ovf_q, ovf_d;

    logic       ser_load;
    logic [7:0] ser_data;
    logic       ser_tx;
    logic       ser_idle;
    logic       ser_pre_last;
    logic       ser_last;

    uart_byte_serializer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_ser (
        .clk_i      (clock),
        .rst_i      (reset),
        .load_i     (ser_load),
        .data_i     (ser_data),
        .tx_o       (ser_tx),
        .idle_o     (ser_idle),
        .pre_last_o (ser_pre_last),
        .last_o     (ser_last)
    );

    // Packet sequencing registers
    always_ff @(posedge clock) begin
        if (reset) begin
            byte_sel_q  <= 1'b0;
            pkt_val_q   <= '0;
            hold_full_q <= 1'b0;
            hold_cmd_q  <= '0;
            hold_val_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            byte_sel_q  <= byte_sel_d;
            pkt_val_q   <= pkt_val_d;
            hold_full_q <= hold_full_d;
            hold_cmd_q  <= hold_cmd_d;
            hold_val_q  <= hold_val_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
        end
    end

    // Acceptance, byte chaining and holding-register launch
    always_comb begin
        byte_sel_d  = byte_sel_q;
        pkt_val_d   = pkt_val_q;
        hold_full_d = hold_full_q;
        hold_cmd_d  = hold_cmd_q;
        hold_val_d  = hold_val_q;
        ovf_d       = ovf_q;
        ser_load    = 1'b0;
        ser_data    = '0;

        if (ser_idle && !hold_full_q) begin
            if (bus.dadosPodemSerEnviados) begin
                ser_load   = 1'b1;
                ser_data   = bus.response_command;
                pkt_val_d  = bus.response_value;
                byte_sel_d = 1'b0;
            end
        end else begin
            if (bus.dadosPodemSerEnviados) begin
                if (hold_full_q) begin
                    ovf_d = 1'b1;
                end else begin
                    hold_full_d = 1'b1;
                    hold_cmd_d  = bus.response_command;
                    hold_val_d  = bus.response_value;
                end
            end

            if (ser_idle) begin
                // Packet parked during the previous completion edge
                ser_load    = 1'b1;
                ser_data    = hold_cmd_q;
                pkt_val_d   = hold_val_q;
                byte_sel_d  = 1'b0;
                hold_full_d = 1'b0;
            end else if (ser_last) begin
                if (!byte_sel_q) begin
                    ser_load   = 1'b1;
                    ser_data   = pkt_val_q;
                    byte_sel_d = 1'b1;
                end else if (hold_full_q) begin
                    ser_load    = 1'b1;
                    ser_data    = hold_cmd_q;
                    pkt_val_d   = hold_val_q;
                    byte_sel_d  = 1'b0;
                    hold_full_d = 1'b0;
                end
            end
        end

        busy_d = ser_load ? 1'b1 : (ser_last ? 1'b0 : busy_q);
        done_d = ser_pre_last && byte_sel_q;
    end

    assign bus.tx          = ser_tx;
    assign bus.busy        = busy_q;
    assign bus.packet_done = done_q;
    assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_response_uart_tx.sv
// tb/tb_response_uart_tx.sv - directed self-checking bench for response_uart_tx
module tb_response_uart_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    response_uart_tx_if bus_if ();

    response_uart_tx #(
        .CLK_FREQ (80),
        .BAUD     (10)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus_if.dadosPodemSerEnviados = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] c, input logic [7:0] v);
        bus_if.dadosPodemSerEnviados = 1'b1;
        bus_if.response_command      = c;
        bus_if.response_value        = v;
    endtask

    // Called in the first cycle after acceptance (n=0); walks cycles 0..last_n
    task automatic watch(input logic [7:0] c, input logic [7:0] v, input string tag,
                         input int last_n,
                         input int i0, input logic [7:0] c0, input logic [7:0] v0,
                         input int i1, input logic [7:0] c1, input logic [7:0] v1);
        logic [19:0] fr;
        fr = {1'b1, v, 1'b0, 1'b1, c, 1'b0};
        for (int n = 0; n <= last_n; n++) begin
            chk($sformatf("%s tx n=%0d", tag, n), bus_if.tx, fr[n/8]);
            chk($sformatf("%s busy n=%0d", tag, n), bus_if.busy, 1'b1);
            chk($sformatf("%s done n=%0d", tag, n), bus_if.packet_done, (n == 159));
            if (n == i0)      pulse(c0, v0);
            else if (n == i1) pulse(c1, v1);
            if (n < last_n) tick();
        end
    endtask

    task automatic check_idle(input string tag, input logic ovf);
        chk({tag, " tx"}, bus_if.tx, 1'b1);
        chk({tag, " busy"}, bus_if.busy, 1'b0);
        chk({tag, " done"}, bus_if.packet_done, 1'b0);
        chk({tag, " ovf"}, bus_if.overflow, ovf);
    endtask

    initial begin
        bus_if.dadosPodemSerEnviados = 1'b0;
        bus_if.response_command      = 8'h00;
        bus_if.response_value        = 8'h00;

        repeat (3) tick();
        check_idle("reset", 1'b0);
        rst = 1'b0;
        tick();
        check_idle("post_reset", 1'b0);

        // Single packet 0x09/0x1B, value input changed after acceptance
        pulse(8'h09, 8'h1B);
        tick();
        bus_if.response_value = 8'hFF;
        watch(8'h09, 8'h1B, "single", 159, -1, 8'h00, 8'h00, -1, 8'h00, 8'h00);
        tick();
        check_idle("single_end", 1'b0);
        tick();

        // Back-to-back: second packet parked in holding, launched without a gap
        pulse(8'h08, 8'h32);
        tick();
        watch(8'h08, 8'h32, "b2b_1", 159, 39, 8'h09, 8'h19, -1, 8'h00, 8'h00);
        tick();
        watch(8'h09, 8'h19, "b2b_2", 159, -1, 8'h00, 8'h00, -1, 8'h00, 8'h00);
        tick();
        check_idle("b2b_end", 1'b0);
        tick();

        // Pulse coincident with completion: exactly one idle cycle before launch
        pulse(8'h45, 8'h1F);
        tick();
        watch(8'h45, 8'h1F, "simul_1", 159, 159, 8'hAA, 8'hAA, -1, 8'h00, 8'h00);
        tick();
        check_idle("simul_gap", 1'b0);
        tick();
        watch(8'hAA, 8'hAA, "simul_2", 159, -1, 8'h00, 8'h00, -1, 8'h00, 8'h00);
        tick();
        check_idle("simul_end", 1'b0);
        tick();

        // Overflow: third pulse during one packet is dropped
        pulse(8'h01, 8'h01);
        tick();
        watch(8'h01, 8'h01, "ovf_1", 159, 10, 8'h02, 8'h02, 20, 8'h03, 8'h03);
        tick();
        chk("ovf_sticky_mid", bus_if.overflow, 1'b1);
        watch(8'h02, 8'h02, "ovf_2", 159, -1, 8'h00, 8'h00, -1, 8'h00, 8'h00);
        tick();
        check_idle("ovf_end", 1'b1);
        for (int n = 0; n < 20; n++) begin
            tick();
            chk($sformatf("ovf_no_pkt3 tx n=%0d", n), bus_if.tx, 1'b1);
            chk($sformatf("ovf_hold n=%0d", n), bus_if.overflow, 1'b1);
        end

        // Reset at command data bit 5 (frame bit 6)
        pulse(8'hFF, 8'h00);
        tick();
        watch(8'hFF, 8'h00, "rst_mid", 50, -1, 8'h00, 8'h00, -1, 8'h00, 8'h00);
        rst = 1'b1;
        tick();
        check_idle("rst_mid_after", 1'b0);
        rst = 1'b0;
        for (int n = 0; n < 170; n++) begin
            tick();
            chk($sformatf("rst_quiet tx n=%0d", n), bus_if.tx, 1'b1);
            chk($sformatf("rst_quiet done n=%0d", n), bus_if.packet_done, 1'b0);
            chk($sformatf("rst_quiet busy n=%0d", n), bus_if.busy, 1'b0);
        end
        pulse(8'h07, 8'h07);
        tick();
        watch(8'h07, 8'h07, "after_rst", 159, -1, 8'h00, 8'h00, -1, 8'h00, 8'h00);
        tick();
        check_idle("after_rst_end", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/response_uart_tx.md
# response_uart_tx

Serializes each sensor response packet onto an 8N1 UART line toward the host. Sits directly downstream of the sensor-connection stage and consumes its `dadosPodemSerEnviados` pulse together with `response_command` / `response_value`. Each packet goes out as two bytes, command then value. A one-entry holding register absorbs a packet that arrives while the line is busy.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000: clock frequency in Hz.
- `BAUD`, 9600: line rate in bits/s.
- `CLKS_PER_BIT`, `CLK_FREQ/BAUD` (5208): cycles per bit, integer division. Must be ≥ 2.

Ports:
- `clock`  in  1: single clock. One clock; reset is synchronous and active-high.
- `reset`  in  1: synchronous, active-high.
- `dadosPodemSerEnviados`  in  1: one-cycle pulse; packet valid.
- `response_command`  in  8: command byte, sampled in the pulse cycle.
- `response_value`  in  8: value byte, sampled in the pulse cycle.
- `tx`  out  1: UART line, idle high.
- `busy`  out  1: a packet is being shifted out.
- `packet_done`  out  1: one-cycle pulse when the second stop bit completes.
- `overflow`  out  1: sticky; a packet was dropped. Cleared only by reset.

## Operation
- Frame per byte: start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts exactly `CLKS_PER_BIT` cycles.
- The value byte's start bit follows the command byte's stop bit with no gap.
- Packet length is 20 bit times.
- FSM states: IDLE, START, DATA, STOP. A `byte_sel` flag (0 = command, 1 = value) selects the byte.
  - IDLE→START when a packet is accepted.
  - START→DATA after 1 bit time.
  - DATA→STOP after 8 bit times.
  - STOP with `byte_sel`=0 → START and set `byte_sel`=1.
  - STOP with `byte_sel`=1 → completion.
- Acceptance rules, applied in the pulse cycle:
  - FSM in IDLE: latch both bytes into the shift register; transmission starts.
  - Busy with holding empty: store both bytes in the holding register.
  - Busy with holding full: drop the packet and set `overflow`=1.
- Completion, i.e. the last cycle of the second stop bit:
  - Pulse `packet_done`.
  - If holding is full: load the shift register from holding, clear holding, enter START at that same edge. `busy` stays 1.
  - Otherwise: go to IDLE and drop `busy`.
- Simultaneous pulse and completion with holding empty: the pulse is stored in holding. It launches at the next edge, after exactly one idle cycle with `tx`=1 and `busy`=0.
- Inputs are not re-sampled after acceptance. Upstream changes to `response_*` during transmission have no effect.
- Reset values: `tx`=1, `busy`=0, `packet_done`=0, `overflow`=0, holding empty, FSM in IDLE, bit and cycle counters 0.
- Reset mid-packet aborts the packet. `tx` is 1 from the next cycle. No `packet_done` is issued and the holding contents are discarded.

## Timing
- Pulse sampled at edge E0 while IDLE: `tx`=0 and `busy`=1 from E0+1.
- Bit k (0..19) occupies cycles [E0+1+k·CPB, E0+1+(k+1)·CPB).
- `packet_done`=1 in cycle E0+20·CPB, which is the last stop-bit cycle.
- `busy` falls at edge E0+1+20·CPB unless the holding register launches a new packet.
- All outputs are registered. `tx` has no combinational path from any input.
- The cycle counter counts 0..CPB-1. Its width is `$clog2(CLKS_PER_BIT)`. The bit counter counts 0..7 (3 bits).

## Structure
- Shared package `uart_pkg`:
  - FSM state localparams (IDLE, START, DATA, STOP).
  - `START_BIT`=0, `STOP_BIT`=1, `BITS_PER_BYTE`=8.
  - Response command codes used by the host: 0x07, 0x08, 0x09, 0x1F, 0x45, 0xAA, 0xFF.
- Sub-module `uart_byte_serializer`: one-byte 8N1 shifter with load/done handshake and its own baud counter.
- Top level: packet sequencing, holding register, overflow flag.

## Test plan
Bench uses CLK_FREQ=80, BAUD=10, so CPB=8.
- Single packet: pulse with cmd=0x09, val=0x1B. The `tx` bit stream is 0,1001_0000,1,0,1101_1000,1, each bit held 8 cycles. `packet_done` fires at cycle 160 after the pulse. `busy`=0 at cycle 161.
- Back-to-back: pulse 0x08/0x32, then a second pulse 0x09/0x19 at cycle 40.
  - The second packet starts with no idle cycle after the first `packet_done`.
  - `busy` stays high for 320 cycles and `overflow`=0.
- Overflow: three pulses during one packet (0x01/0x01, 0x02/0x02, 0x03/0x03). Packet 3 is dropped and `overflow`=1 until reset. Only packets 1 and 2 appear on `tx`.
- Simultaneous pulse and completion: pulse 0xAA/0xAA in the `packet_done` cycle. `tx`=1 and `busy`=0 for exactly one cycle, then the start bit of 0xAA.
- Reset mid-packet: assert `reset` at bit 5 of the command byte.
  - `tx`=1 and `busy`=0 at the next cycle; no `packet_done`.
  - A subsequent pulse 0x07/0x07 transmits cleanly.
- Input stability: change `response_value` from 0x1B to 0xFF during transmission. The transmitted value stays 0x1B.
